// File: rtl/cnn_pkg.sv
// Shared types and sizing helpers for the conv/pool/FC scheduler.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_FC,
    S_DONE
  } state_e;

  localparam int DEF_IMG_DIM = 64;
  localparam int DEF_TILE    = 8;
  localparam int DEF_PAD     = 2;

  function automatic int win_size(input int tile, input int pad);
    return tile + 2 * pad;
  endfunction

  function automatic int addr_width(input int img_dim);
    return 2 * $clog2(img_dim);
  endfunction

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Nested tile/window position counters and the padded BRAM address they map to.
module win_addr_gen
  import cnn_pkg::*;
#(
  parameter int  IMG_DIM = DEF_IMG_DIM,
  parameter int  TILE    = DEF_TILE,
  parameter int  PAD     = DEF_PAD,
  localparam int AW      = addr_width(IMG_DIM),
  localparam int UW      = bits_for((IMG_DIM / TILE) * (IMG_DIM / TILE))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          pad,
  output logic [UW-1:0] unit_sel,
  output logic          tile_first,
  output logic          tile_last,
  output logic          last_pos
);

  localparam int WIN      = win_size(TILE, PAD);
  localparam int TILES_1D = IMG_DIM / TILE;
  localparam int LOG      = $clog2(IMG_DIM);
  localparam int RW       = LOG + 2;
  localparam int CW       = bits_for(WIN);
  localparam int TW       = bits_for(TILES_1D);

  localparam logic [CW-1:0]        WIN_MAX = CW'(WIN - 1);
  localparam logic [TW-1:0]        T_MAX   = TW'(TILES_1D - 1);
  localparam logic signed [RW-1:0] DIM_S   = RW'(IMG_DIM);

  logic [CW-1:0] in_c_q, in_c_d, in_r_q, in_r_d;
  logic [TW-1:0] out_j_q, out_j_d, out_i_q, out_i_d;
  logic signed [RW-1:0] row_s, col_s;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    in_c_d  = in_c_q;
    in_r_d  = in_r_q;
    out_j_d = out_j_q;
    out_i_d = out_i_q;
    if (clr) begin
      in_c_d  = '0;
      in_r_d  = '0;
      out_j_d = '0;
      out_i_d = '0;
    end else if (inc) begin
      if (in_c_q != WIN_MAX) begin
        in_c_d = in_c_q + CW'(1);
      end else begin
        in_c_d = '0;
        if (in_r_q != WIN_MAX) begin
          in_r_d = in_r_q + CW'(1);
        end else begin
          in_r_d = '0;
          if (out_j_q != T_MAX) begin
            out_j_d = out_j_q + TW'(1);
          end else begin
            out_j_d = '0;
            out_i_d = (out_i_q == T_MAX) ? '0 : out_i_q + TW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      in_c_q  <= '0;
      in_r_q  <= '0;
      out_j_q <= '0;
      out_i_q <= '0;
    end else begin
      in_c_q  <= in_c_d;
      in_r_q  <= in_r_d;
      out_j_q <= out_j_d;
      out_i_q <= out_i_d;
    end
  end

  // Window origin sits PAD pixels up/left of the tile, so row/col may go negative.
  always_comb begin
    row_s      = RW'(int'(out_i_q) * TILE + int'(in_r_q) - PAD);
    col_s      = RW'(int'(out_j_q) * TILE + int'(in_c_q) - PAD);
    pad        = row_s[RW-1] | col_s[RW-1] | (row_s >= DIM_S) | (col_s >= DIM_S);
    addr       = pad ? '0 : {row_s[LOG-1:0], col_s[LOG-1:0]};
    unit_sel   = UW'(int'(out_i_q) * TILES_1D + int'(out_j_q));
    tile_first = (in_r_q == '0) && (in_c_q == '0);
    tile_last  = (in_r_q == WIN_MAX) && (in_c_q == WIN_MAX);
    last_pos   = tile_last && (out_j_q == T_MAX) && (out_i_q == T_MAX);
  end

endmodule

// File: rtl/conv_scan_sched.sv
// Single-clock frame scheduler: paced window scan, drain wait, FL hand-off, completion pulse.
module conv_scan_sched
  import cnn_pkg::*;
#(
  parameter int  IMG_DIM   = DEF_IMG_DIM,
  parameter int  TILE      = DEF_TILE,
  parameter int  PAD       = DEF_PAD,
  parameter int  STEP_DIV  = 4,
  parameter int  DRAIN_CYC = 16,
  localparam int AW        = addr_width(IMG_DIM),
  localparam int UW        = bits_for((IMG_DIM / TILE) * (IMG_DIM / TILE))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pipe_ready,
  input  logic          fl_done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          pad,
  output logic [UW-1:0] unit_sel,
  output logic          tile_first,
  output logic          tile_last,
  output logic          fl_start,
  output logic          busy,
  output logic          done
);

  localparam int PW = bits_for(STEP_DIV);
  localparam int DW = bits_for(DRAIN_CYC);
  localparam logic [PW-1:0] P_MAX = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] D_MAX = DW'(DRAIN_CYC - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          fl_sent_q, fl_sent_d;
  logic          issue, clr;

  logic [AW-1:0] g_addr;
  logic [UW-1:0] g_unit;
  logic          g_pad, g_first, g_last, g_final;

  logic          rd_en_q, rd_en_d, pad_q, pad_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [UW-1:0] unit_sel_q, unit_sel_d;
  logic          tile_first_q, tile_first_d, tile_last_q, tile_last_d;
  logic          fl_start_q, fl_start_d, busy_q, busy_d, done_q, done_d;

  win_addr_gen #(
    .IMG_DIM(IMG_DIM),
    .TILE   (TILE),
    .PAD    (PAD)
  ) u_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .inc       (issue),
    .addr      (g_addr),
    .pad       (g_pad),
    .unit_sel  (g_unit),
    .tile_first(g_first),
    .tile_last (g_last),
    .last_pos  (g_final)
  );

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    drain_d   = '0;
    fl_sent_d = 1'b0;
    issue     = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (start) begin
          state_d = S_SCAN;
          clr     = 1'b1;
        end
      end
      S_SCAN: begin
        // A stall only freezes the prescaler at zero; mid-period it keeps counting.
        if (presc_q != '0 || pipe_ready) begin
          issue   = (presc_q == '0);
          presc_d = (presc_q == P_MAX) ? '0 : presc_q + PW'(1);
          if (issue && g_final) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == D_MAX) begin
          drain_d = '0;
          state_d = S_FC;
        end
      end
      S_FC: begin
        fl_sent_d = 1'b1;
        if (fl_done) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_en_d      = issue;
    rd_addr_d    = issue ? g_addr : '0;
    pad_d        = issue & g_pad;
    unit_sel_d   = issue ? g_unit : '0;
    tile_first_d = issue & g_first;
    tile_last_d  = issue & g_last;
    fl_start_d   = (state_q == S_FC) && !fl_sent_q;
    done_d       = (state_q == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      drain_q      <= '0;
      fl_sent_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      pad_q        <= 1'b0;
      unit_sel_q   <= '0;
      tile_first_q <= 1'b0;
      tile_last_q  <= 1'b0;
      fl_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      drain_q      <= drain_d;
      fl_sent_q    <= fl_sent_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      pad_q        <= pad_d;
      unit_sel_q   <= unit_sel_d;
      tile_first_q <= tile_first_d;
      tile_last_q  <= tile_last_d;
      fl_start_q   <= fl_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pad        = pad_q;
  assign unit_sel   = unit_sel_q;
  assign tile_first = tile_first_q;
  assign tile_last  = tile_last_q;
  assign fl_start   = fl_start_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_conv_scan_sched.sv
// Scoreboard bench: two scheduler instances (STEP_DIV=1 and STEP_DIV=4) on a 16x16 image.
module tb_conv_scan_sched;

  localparam int IMG = 16;
  localparam int TL  = 8;
  localparam int PD  = 2;
  localparam int W   = TL + 2 * PD;
  localparam int T1  = IMG / TL;
  localparam int NSTROBE = T1 * T1 * W * W;

  typedef struct packed {
    logic [7:0] addr;
    logic       pad;
    logic [1:0] unit;
    logic       first;
    logic       last;
  } strobe_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst1, start1, pr1, fld1, rd_en1, pad1, first1, last1, fls1, busy1, done1;
  logic [7:0] addr1;
  logic [1:0] unit1;
  logic       rst4, start4, pr4, fld4, rd_en4, pad4, first4, last4, fls4, busy4, done4;
  logic [7:0] addr4;
  logic [1:0] unit4;

  conv_scan_sched #(
    .IMG_DIM(IMG), .TILE(TL), .PAD(PD), .STEP_DIV(1), .DRAIN_CYC(16)
  ) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .pipe_ready(pr1), .fl_done(fld1),
    .rd_en(rd_en1), .rd_addr(addr1), .pad(pad1), .unit_sel(unit1),
    .tile_first(first1), .tile_last(last1), .fl_start(fls1), .busy(busy1), .done(done1)
  );

  conv_scan_sched #(
    .IMG_DIM(IMG), .TILE(TL), .PAD(PD), .STEP_DIV(4), .DRAIN_CYC(16)
  ) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .pipe_ready(pr4), .fl_done(fld4),
    .rd_en(rd_en4), .rd_addr(addr4), .pad(pad4), .unit_sel(unit4),
    .tile_first(first4), .tile_last(last4), .fl_start(fls4), .busy(busy4), .done(done4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  strobe_t q1[$];
  strobe_t q4[$];
  strobe_t obs1[NSTROBE];
  int cnt1 = 0, cnt4 = 0, last1_cyc = 0, last4_cyc = 0;

  // Reference model straight from the window definition.
  task automatic push_frame(input bit to4);
    strobe_t s;
    int row, col;
    for (int oi = 0; oi < T1; oi++)
      for (int oj = 0; oj < T1; oj++)
        for (int r = 0; r < W; r++)
          for (int c = 0; c < W; c++) begin
            row     = oi * TL + r - PD;
            col     = oj * TL + c - PD;
            s.pad   = (row < 0) || (row >= IMG) || (col < 0) || (col >= IMG);
            s.addr  = s.pad ? 8'd0 : 8'(row * IMG + col);
            s.unit  = 2'(oi * T1 + oj);
            s.first = (r == 0) && (c == 0);
            s.last  = (r == W - 1) && (c == W - 1);
            if (to4) q4.push_back(s);
            else q1.push_back(s);
          end
  endtask

  strobe_t m1_o, m1_e, m4_o, m4_e;

  always @(negedge clk) begin
    if (rd_en1) begin
      m1_o = {addr1, pad1, unit1, first1, last1};
      if (cnt1 < NSTROBE) obs1[cnt1] = m1_o;
      cnt1++;
      last1_cyc = cyc;
      check("sb1_pending", 64'(q1.size() > 0), 64'd1);
      if (q1.size() > 0) begin
        m1_e = q1.pop_front();
        check("sb1_strobe", m1_o, m1_e);
      end
    end
    if (rd_en4) begin
      m4_o = {addr4, pad4, unit4, first4, last4};
      cnt4++;
      last4_cyc = cyc;
      check("sb4_pending", 64'(q4.size() > 0), 64'd1);
      if (q4.size() > 0) begin
        m4_e = q4.pop_front();
        check("sb4_strobe", m4_o, m4_e);
      end
    end
  end

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return rd_en4;
      1:       return fls1;
      2:       return done1;
      3:       return fls4;
      default: return done4;
    endcase
  endfunction

  task automatic wait_high(input int sel, input int budget, output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig_of(sel) && n < budget);
    at = cyc;
    check($sformatf("wait_sig%0d", sel), sig_of(sel), 1'b1);
  endtask

  task automatic wait_cnt(input bit which, input int target, input int budget);
    int n = 0;
    while (((which ? cnt4 : cnt1) < target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(which ? "cnt4_reach" : "cnt1_reach", which ? cnt4 : cnt1, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, ta, tb, tf, td;
    logic seen;

    rst1 = 1'b1; start1 = 1'b0; pr1 = 1'b1; fld1 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; pr4 = 1'b1; fld4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst1_outs", {rd_en1, addr1, pad1, unit1, first1, last1, fls1, busy1, done1}, '0);
    check("rst4_outs", {rd_en4, addr4, pad4, unit4, first4, last4, fls4, busy4, done4}, '0);
    rst1 = 1'b0;
    rst4 = 1'b0;
    repeat (2) @(negedge clk);

    // Frame A on dut1: full sequence, start latency, spurious start mid-scan.
    cnt1 = 0;
    push_frame(1'b0);
    start1 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start1 = 1'b0;
    check("a_busy_rise", busy1, 1'b1);
    check("a_no_rd_yet", rd_en1, 1'b0);
    @(negedge clk);
    check("a_first_lat", {rd_en1, 32'(cyc - t0)}, {1'b1, 32'd2});
    repeat (20) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_cnt(1'b0, NSTROBE, 800);
    check("a_obs0", obs1[0], {8'd0, 1'b1, 2'd0, 1'b1, 1'b0});
    check("a_obs26", {obs1[26].pad, obs1[26].addr}, {1'b0, 8'd0});
    check("a_obs168", {obs1[168].unit, obs1[168].addr, obs1[168].pad}, {2'd1, 8'd6, 1'b0});
    check("a_obs179", {obs1[179].pad, obs1[179].addr}, {1'b1, 8'd0});
    wait_high(1, 40, tf);
    check("a_fl_lat", tf - last1_cyc, 17);
    check("a_count", cnt1, NSTROBE);
    check("a_q_empty", q1.size(), 0);
    @(negedge clk);
    check("a_fl_pulse", fls1, 1'b0);
    repeat (4) @(negedge clk);
    fld1 = 1'b1;
    td = cyc;
    @(negedge clk);
    fld1 = 1'b0;
    check("a_busy_fc", {busy1, done1}, {1'b1, 1'b0});
    @(negedge clk);
    check("a_done", {32'(cyc - td), done1, busy1}, {32'd2, 1'b1, 1'b0});
    @(negedge clk);
    check("a_done_pulse", done1, 1'b0);

    // Frame B on dut1: reset during DRAIN aborts silently.
    cnt1 = 0;
    push_frame(1'b0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_cnt(1'b0, NSTROBE, 800);
    repeat (3) @(negedge clk);
    check("b_in_drain", {busy1, fls1}, {1'b1, 1'b0});
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    check("b_rst_outs", {busy1, fls1, done1}, '0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | fls1 | done1 | busy1 | rd_en1;
    end
    check("b_no_resume", seen, 1'b0);

    // Frame C on dut1: clean restart from unit 0.
    cnt1 = 0;
    push_frame(1'b0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_cnt(1'b0, NSTROBE, 800);
    wait_high(1, 40, tf);
    check("c_fl_lat", tf - last1_cyc, 17);
    fld1 = 1'b1;
    @(negedge clk);
    fld1 = 1'b0;
    wait_high(2, 10, td);
    check("c_q_empty", q1.size(), 0);

    // Frame D on dut4: pacing, stall, early fl_done ignored.
    cnt4 = 0;
    push_frame(1'b1);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_high(0, 20, ta);
    for (int k = 0; k < 4; k++) begin
      wait_high(0, 20, tb);
      check("d_gap", tb - ta, 4);
      ta = tb;
    end
    repeat (7) @(negedge clk);
    pr4 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("d_stall", rd_en4, 1'b0);
    end
    pr4 = 1'b1;
    wait_cnt(1'b1, NSTROBE, 3000);
    @(negedge clk);
    fld4 = 1'b1;
    @(negedge clk);
    fld4 = 1'b0;
    wait_high(3, 40, tf);
    check("d_fl_lat", tf - last4_cyc, 17);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done4;
    end
    check("d_early_fld_ignored", {seen, busy4}, {1'b0, 1'b1});
    fld4 = 1'b1;
    @(negedge clk);
    fld4 = 1'b0;
    wait_high(4, 10, td);
    check("d_busy_low", busy4, 1'b0);
    check("d_count", cnt4, NSTROBE);
    check("d_q_empty", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_scan_sched.md
Name: conv_scan_sched

Overview:
- Single-clock scheduler for the conv/pool/FC datapath. It replaces the divided-clock chain (counter_out, counter_in, per-unit enable shifter, FL start logic) with clock-enabled sequencing.
- Walks the image tile by tile over a padded window and issues one image-BRAM read per window position, with a pad flag and the target unit index.
- After a fixed drain period, hands off to the FL stage and reports completion.

Parameters:
- IMG_DIM, 64, image side in pixels (power of 2)
- TILE, 8, tile side; one conv unit per tile
- PAD, 2, padding on every tile edge
- STEP_DIV, 4, clk cycles per issued pixel (≥1)
- DRAIN_CYC, 16, cycles waited after the last issue before fl_start
- Derived: WIN=TILE+2*PAD; TILES_1D=IMG_DIM/TILE; NUM_UNITS=TILES_1D²; AW=2*log2(IMG_DIM)

Ports:
- clk, in, 1, system clock
- rst, in, 1, synchronous active-high reset
- start, in, 1, begin one frame; ignored unless idle
- pipe_ready, in, 1, downstream can accept a pixel; low stalls issue
- fl_done, in, 1, FL stage finished (level or pulse)
- rd_en, out, 1, one-cycle strobe, one per window position
- rd_addr, out, AW, BRAM address row*IMG_DIM+col; 0 when pad
- pad, out, 1, this position lies outside the image; datapath injects 0
- unit_sel, out, log2(NUM_UNITS), unit owning the current tile, = out_i*TILES_1D+out_j
- tile_first, out, 1, with rd_en: first position of a tile
- tile_last, out, 1, with rd_en: last position of a tile
- fl_start, out, 1, one-cycle pulse
- busy, out, 1, high in every state except IDLE
- done, out, 1, one-cycle pulse at frame end

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- rst asserted mid-operation aborts the frame at the next edge with no done pulse.
- FSM states and transitions:
  - IDLE: on start → SCAN; clear counters and prescaler.
  - SCAN → DRAIN: the cycle after the final issue is accepted.
  - DRAIN: counts DRAIN_CYC cycles → FC.
  - FC: fl_start pulses on the first cycle only, then waits for fl_done → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - A start in IDLE during the same cycle as the DONE→IDLE transition is not seen; start is sampled in IDLE only.
- Prescaler (SCAN only):
  - Counts 0..STEP_DIV-1. An issue occurs when prescaler==0 and pipe_ready==1.
  - If pipe_ready==0 at prescaler==0, the prescaler holds at 0 (stall) and no counter advances.
  - With STEP_DIV=1, issue is possible every cycle.
- Counter nesting, incremented on issue:
  - in_c 0..WIN-1 (innermost), then in_r 0..WIN-1, then out_j 0..TILES_1D-1, then out_i 0..TILES_1D-1.
  - Final issue: all four counters at their maxima.
- Address arithmetic:
  - row = out_i*TILE + in_r − PAD, signed, width log2(IMG_DIM)+2; col is formed the same way.
  - pad=1 iff row<0, row≥IMG_DIM, col<0 or col≥IMG_DIM.
- Output timing:
  - All outputs are registered. rd_en, rd_addr, pad, unit_sel, tile_first and tile_last reflect an issue one cycle after the issuing edge.
  - tile_first ⇔ in_r=in_c=0; tile_last ⇔ in_r=in_c=WIN-1.
- Totals and latency:
  - Issues per frame = NUM_UNITS*WIN² exactly.
  - First rd_en appears 2 cycles after start is sampled (SCAN entry, then registered output).
- fl_done arriving before FC is ignored.

Decomposition:
- Shared package cnn_pkg holds:
  - the FSM state enum (IDLE, SCAN, DRAIN, FC, DONE);
  - default IMG_DIM/TILE/PAD constants;
  - a function computing WIN and address width.
- One natural sub-module, win_addr_gen:
  - the four nested counters plus the signed row/col/pad/address computation;
  - increment input = issue.
- The FSM and prescaler stay in the top module.

Test Plan:
1. IMG_DIM=16, TILE=8, PAD=2, STEP_DIV=1, pipe_ready=1, start pulse:
   - exactly 576 rd_en strobes;
   - 1st strobe pad=1, unit_sel=0, tile_first=1;
   - 27th strobe (in_r=2, in_c=2) pad=0, rd_addr=0.
2. Same configuration, tile 1:
   - the strobe at in_r=2, in_c=0 gives unit_sel=1, rd_addr=6;
   - the strobe at in_r=2, in_c=11 gives col=17 → pad=1, rd_addr=0.
3. STEP_DIV=4:
   - consecutive rd_en strobes exactly 4 cycles apart;
   - pipe_ready held low for 10 cycles mid-scan → no rd_en during the stall, sequence resumes at the next position with no skip or duplicate.
4. End of frame with DRAIN_CYC=16:
   - fl_start pulses exactly 17 cycles after the last rd_en;
   - fl_done driven 5 cycles later → done pulse 2 cycles after that; busy falls with done.
5. start re-asserted during SCAN → ignored, count stays 576.
6. rst asserted in DRAIN → next cycle busy=0, no fl_start or done; a new start runs a complete frame from unit 0.
